jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller that is the DUT consuming the stimulus driven by jtag_agent_a and returning TDO to the passive jtag_agent_b.
- Contains the 16-state TAP FSM, an instruction register, and three data registers: BYPASS, IDCODE and an 8-bit USER register.
- The USER register is exposed to the core as parallel in/out.

Parameters:
IR_WIDTH, 4, instruction register width in bits (minimum 2).
DATA_WIDTH, 8, USER data register width.
IDCODE_VAL, 32'h1A2B_C0DF, value captured by IDCODE; bit0 must be 1.

Ports:
clk  input  1  TCK; all state advances on the rising edge; tdo launches on the falling edge.
rst_n  input  1  TRST*, asynchronous, active-low.
tms  input  1  test mode select, sampled on the clk rising edge.
tdi  input  1  test data in, sampled on the clk rising edge in Shift-IR/Shift-DR.
tdo  output  1  test data out; 0 when tdo_en=0.
tdo_en  output  1  high while the FSM is in Shift-IR or Shift-DR (falling-edge registered).
user_in  input  DATA_WIDTH  parallel value captured into the USER DR in Capture-DR.
user_out  output  DATA_WIDTH  USER register contents, updated in Update-DR.
user_update  output  1  one-cycle pulse in the cycle after Update-DR with USER selected.
tap_state  output  4  current FSM state encoding, for debug and coverage.
ir_out  output  IR_WIDTH  currently active (updated) instruction.

Behaviour:
- Reset is asynchronous (rst_n=0). While rst_n=0:
  - tap_state=Test-Logic-Reset (0x0); ir_out=IDCODE (4'b0001).
  - user_out=0; user_update=0; tdo=0; tdo_en=0.
  - All shift registers are cleared.
  - Reset mid-shift discards partial data; user_out is not updated.
- State encoding:
  - TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8.
  - SelIR=9, CapIR=A, ShIR=B, Ex1IR=C, PauIR=D, Ex2IR=E, UpdIR=F.
- Transitions follow 1149.1 exactly:
  - TLR: tms=0 -> RTI; tms=1 -> TLR.
  - RTI: tms=1 -> SelDR.
  - SelDR: tms=0 -> CapDR; tms=1 -> SelIR.
  - SelIR: tms=0 -> CapIR; tms=1 -> TLR.
  - Cap: tms=0 -> Sh; tms=1 -> Ex1.
  - Sh: tms=1 -> Ex1.
  - Ex1: tms=0 -> Pau; tms=1 -> Upd.
  - Pau: tms=1 -> Ex2.
  - Ex2: tms=0 -> Sh; tms=1 -> Upd.
  - Upd: tms=0 -> RTI; tms=1 -> SelDR.
  - Any arc not listed holds the current state.
- Five consecutive tms=1 edges reach TLR from any state. Entering TLR forces ir_out=IDCODE.
- Instruction decode:
  - 4'b0001 = IDCODE; 4'b0010 = USER; 4'b1111 = BYPASS.
  - Every other code, including 4'b0000, selects BYPASS.
- IR path:
  - CapIR loads the IR shift register with {0..0,01}.
  - ShIR shifts right: tdi enters the MSB; the LSB goes to tdo.
  - UpdIR copies the shift register to ir_out on that rising edge.
- DR path, selected by ir_out:
  - CapDR loads the selected register: BYPASS<=0, IDCODE<=IDCODE_VAL, USER<=user_in.
  - ShDR shifts right, LSB first, through the selected register only.
  - BYPASS is a 1-cycle delay from tdi to tdo.
- USER update:
  - UpdDR with USER selected copies the USER shift register to user_out.
  - user_update pulses for exactly one clk.
  - UpdDR with IDCODE or BYPASS selected has no side effect.
- TDO:
  - On each falling edge, tdo/tdo_en sample the LSB of the active shift register and the "state is ShIR/ShDR" flag.
  - The bit visible on a rising edge is therefore the one shifted out on that edge.
- The exit edge out of Sh (tms=1) still shifts one bit, as in 1149.1; Pause holds the shift register contents.
- Shifting more than the register length recirculates tdi through; only the last N bits matter.

Test Plan:
1. rst_n pulse low mid-ShDR -> tap_state=0, ir_out=4'b0001, user_out=0, tdo_en=0 asynchronously; no user_update.
2. From TLR, tms 0,1,0,0 then 32 shift cycles (tms=1 on the last) -> tdo serial LSB-first equals 32'h1A2B_C0DF.
3. Load IR=4'b1111, then shift DR pattern 1,0,1,1 -> tdo reproduces it delayed by one cycle (X/0 first, then 1,0,1).
4. Load IR=4'b0010 with user_in=8'h3C; shift in 8'hA5 with a Pause-DR detour mid-shift -> tdo emits 8'h3C LSB-first, user_out=8'hA5 after UpdDR, user_update high one cycle.
5. Shift IR 4'b0110 (unlisted) -> Capture-IR outputs 1,0,0,0 on tdo; ir_out=4'b0110 after UpdIR, and a DR scan behaves as BYPASS.
6. From each of the 16 states, apply five tms=1 edges -> TLR every time; full-arc transition coverage is hit by random tms with a reference-model compare of tap_state.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register,
// and BYPASS / IDCODE / USER data registers with parallel USER access.
module jtag_tap_ctrl #(
  parameter int unsigned IR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1A2B_C0DF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  input  logic [DATA_WIDTH-1:0] user_in,
  output logic [DATA_WIDTH-1:0] user_out,
  output logic                  user_update,
  output logic [3:0]            tap_state,
  output logic [IR_WIDTH-1:0]   ir_out
);

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PAU_IR = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } state_e;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(2);

  state_e                  state_q, state_d;
  logic [IR_WIDTH-1:0]     ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]     ir_q, ir_d;
  logic                    byp_q, byp_d;
  logic [31:0]             id_sr_q, id_sr_d;
  logic [DATA_WIDTH-1:0]   usr_sr_q, usr_sr_d;
  logic [DATA_WIDTH-1:0]   uout_q, uout_d;
  logic                    uupd_q, uupd_d;
  logic                    tdo_q, tdo_en_q;
  logic                    sel_id, sel_usr;
  logic                    shift_st, tdo_bit;

  // Any code other than IDCODE or USER routes the DR scan through BYPASS.
  assign sel_id  = (ir_q == IR_IDCODE);
  assign sel_usr = (ir_q == IR_USER);

  // TAP state transition function.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Capture / shift / update actions of the IR and DR paths.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    byp_d    = byp_q;
    id_sr_d  = id_sr_q;
    usr_sr_d = usr_sr_q;
    uout_d   = uout_q;
    uupd_d   = 1'b0;
    unique case (state_q)
      CAP_IR: ir_sr_d = IR_WIDTH'(1);
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d = ir_sr_q;
      CAP_DR: begin
        if (sel_id)       id_sr_d  = IDCODE_VAL;
        else if (sel_usr) usr_sr_d = user_in;
        else              byp_d    = 1'b0;
      end
      SH_DR: begin
        if (sel_id)
          id_sr_d = {tdi, id_sr_q[31:1]};
        else if (sel_usr)
          usr_sr_d = {tdi, usr_sr_q[DATA_WIDTH-1:1]};
        else
          byp_d = tdi;
      end
      UPD_DR: begin
        if (sel_usr) begin
          uout_d = usr_sr_q;
          uupd_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == TLR) ir_d = IR_IDCODE;
  end

  // Rising-edge state and register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TLR;
      ir_sr_q  <= '0;
      ir_q     <= IR_IDCODE;
      byp_q    <= 1'b0;
      id_sr_q  <= '0;
      usr_sr_q <= '0;
      uout_q   <= '0;
      uupd_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      byp_q    <= byp_d;
      id_sr_q  <= id_sr_d;
      usr_sr_q <= usr_sr_d;
      uout_q   <= uout_d;
      uupd_q   <= uupd_d;
    end
  end

  assign shift_st = (state_q == SH_IR) || (state_q == SH_DR);

  assign tdo_bit = (state_q == SH_IR) ? ir_sr_q[0] :
                   sel_id             ? id_sr_q[0] :
                   sel_usr            ? usr_sr_q[0] :
                                        byp_q;

  // TDO launches on the falling edge so it is stable at the next rise.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= shift_st & tdo_bit;
      tdo_en_q <= shift_st;
    end
  end

  assign tdo         = tdo_q;
  assign tdo_en      = tdo_en_q;
  assign user_out    = uout_q;
  assign user_update = uupd_q;
  assign tap_state   = state_q;
  assign ir_out      = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Testbench for jtag_tap_ctrl: directed scans plus random TMS/TDI
// walks compared against a table-driven TAP reference model.
module tb_jtag_tap_ctrl;

  localparam int IRW = 4;
  localparam int DW  = 8;
  localparam logic [31:0] IDV = 32'h1A2B_C0DF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tms = 1'b1;
  logic          tdi = 1'b0;
  logic [DW-1:0] user_in = '0;
  logic          tdo, tdo_en, user_update;
  logic [DW-1:0] user_out;
  logic [3:0]    tap_state;
  logic [IRW-1:0] ir_out;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_tap_ctrl #(
    .IR_WIDTH(IRW),
    .DATA_WIDTH(DW),
    .IDCODE_VAL(IDV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tms(tms),
    .tdi(tdi),
    .tdo(tdo),
    .tdo_en(tdo_en),
    .user_in(user_in),
    .user_out(user_out),
    .user_update(user_update),
    .tap_state(tap_state),
    .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  // Reference model: transition table straight from the 1149.1 arcs.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int             m_st;
  logic [IRW-1:0] m_ir, m_irsr;
  logic           m_byp;
  logic [31:0]    m_id;
  logic [DW-1:0]  m_usr, m_uout;
  logic           m_uupd;
  bit             arc_hit [32];

  logic o_tdo, o_en, e_tdo, e_en;

  function automatic int m_sel();
    if (m_ir == IRW'(1)) return 1;
    if (m_ir == IRW'(2)) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    m_st   = 0;
    m_ir   = IRW'(1);
    m_irsr = '0;
    m_byp  = 1'b0;
    m_id   = '0;
    m_usr  = '0;
    m_uout = '0;
    m_uupd = 1'b0;
  endfunction

  function automatic void model_outputs();
    e_en  = (m_st == 4) || (m_st == 11);
    e_tdo = 1'b0;
    if (m_st == 11) e_tdo = m_irsr[0];
    if (m_st == 4) begin
      case (m_sel())
        1: e_tdo = m_id[0];
        2: e_tdo = m_usr[0];
        default: e_tdo = m_byp;
      endcase
    end
  endfunction

  function automatic void model_edge(logic t, logic d);
    int s;
    s = m_sel();
    m_uupd = 1'b0;
    case (m_st)
      10: m_irsr = IRW'(1);
      11: m_irsr = (m_irsr >> 1) | (IRW'(d) << (IRW - 1));
      15: m_ir = m_irsr;
      3: begin
        if (s == 1)      m_id  = IDV;
        else if (s == 2) m_usr = user_in;
        else             m_byp = 1'b0;
      end
      4: begin
        if (s == 1)      m_id  = (m_id >> 1) | (32'(d) << 31);
        else if (s == 2) m_usr = (m_usr >> 1) | (DW'(d) << (DW - 1));
        else             m_byp = d;
      end
      8: if (s == 2) begin
        m_uout = m_usr;
        m_uupd = 1'b1;
      end
      default: ;
    endcase
    arc_hit[m_st * 2 + int'(t)] = 1'b1;
    m_st = t ? nxt1[m_st] : nxt0[m_st];
    if (m_st == 0) m_ir = IRW'(1);
  endfunction

  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(negedge clk);
    #1;
    o_tdo = tdo;
    o_en  = tdo_en;
    model_outputs();
    @(posedge clk);
    #1;
    model_edge(t, d);
  endtask

  task automatic shift_ir(input logic [IRW-1:0] code,
                          output logic [IRW-1:0] cap);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < IRW; i++) begin
      tick(i == IRW - 1, code[i]);
      cap[i] = o_tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic dr_enter();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (tap_state !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", tap_state);
    end
    n_cmp++;
    if (ir_out !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_ir got %b want 0001", ir_out);
    end
    n_cmp++;
    if (user_out !== 8'h00 || user_update !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_user got %h/%b want 00/0",
               user_out, user_update);
    end
    n_cmp++;
    if (tdo !== 1'b0 || tdo_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tdo got %b/%b want 0/0", tdo, tdo_en);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    bit en_ok;
    en_ok = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick(i == 31, 1'($urandom_range(0, 1)));
      got[i] = o_tdo;
      if (o_en !== 1'b1) en_ok = 1'b0;
    end
    n_cmp++;
    if (got !== IDV) begin
      n_bad++;
      $display("FAIL idcode_scan got %h want %h", got, IDV);
    end
    n_cmp++;
    if (!en_ok) begin
      n_bad++;
      $display("FAIL idcode_tdo_en got 0 want 1 during shift");
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_cmp++;
    if (user_update !== 1'b0 || user_out !== 8'h00) begin
      n_bad++;
      $display("FAIL idcode_upd_side got %b/%h want 0/00",
               user_update, user_out);
    end
  endtask

  task automatic test_bypass();
    logic [IRW-1:0] cap;
    logic [3:0] pat, got;
    pat = 4'b1101;
    shift_ir(4'b1111, cap);
    n_cmp++;
    if (cap !== 4'b0001) begin
      n_bad++;
      $display("FAIL bypass_ircap got %b want 0001", cap);
    end
    n_cmp++;
    if (ir_out !== 4'b1111) begin
      n_bad++;
      $display("FAIL bypass_ir got %b want 1111", ir_out);
    end
    dr_enter();
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, pat[i]);
      got[i] = o_tdo;
    end
    n_cmp++;
    if (got !== 4'b1010) begin
      n_bad++;
      $display("FAIL bypass_delay got %b want 1010", got);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_user();
    logic [IRW-1:0] cap;
    logic [7:0] dat, got;
    dat = 8'hA5;
    shift_ir(4'b0010, cap);
    n_cmp++;
    if (ir_out !== 4'b0010) begin
      n_bad++;
      $display("FAIL user_ir got %b want 0010", ir_out);
    end
    user_in = 8'h3C;
    dr_enter();
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, dat[i]);
      got[i] = o_tdo;
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_cmp++;
    if (o_en !== 1'b0) begin
      n_bad++;
      $display("FAIL user_pause_en got %b want 0", o_en);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 4; i < 8; i++) begin
      tick(i == 7, dat[i]);
      got[i] = o_tdo;
    end
    n_cmp++;
    if (user_out !== 8'h00) begin
      n_bad++;
      $display("FAIL user_early got %h want 00", user_out);
    end
    tick(1'b1, 1'b0);
    n_cmp++;
    if (user_update !== 1'b0) begin
      n_bad++;
      $display("FAIL user_upd_early got %b want 0", user_update);
    end
    tick(1'b0, 1'b0);
    n_cmp++;
    if (user_out !== 8'hA5 || user_update !== 1'b1) begin
      n_bad++;
      $display("FAIL user_update got %h/%b want a5/1",
               user_out, user_update);
    end
    tick(1'b0, 1'b0);
    n_cmp++;
    if (user_update !== 1'b0) begin
      n_bad++;
      $display("FAIL user_pulse_len got %b want 0", user_update);
    end
    n_cmp++;
    if (got !== 8'h3C) begin
      n_bad++;
      $display("FAIL user_capture got %h want 3c", got);
    end
  endtask

  task automatic test_unlisted();
    logic [IRW-1:0] cap;
    logic [2:0] got;
    logic [2:0] pat;
    pat = 3'b011;
    shift_ir(4'b0110, cap);
    n_cmp++;
    if (cap !== 4'b0001) begin
      n_bad++;
      $display("FAIL unl_ircap got %b want 0001", cap);
    end
    n_cmp++;
    if (ir_out !== 4'b0110) begin
      n_bad++;
      $display("FAIL unl_ir got %b want 0110", ir_out);
    end
    dr_enter();
    for (int i = 0; i < 3; i++) begin
      tick(i == 2, pat[i]);
      got[i] = o_tdo;
    end
    n_cmp++;
    if (got !== 3'b110) begin
      n_bad++;
      $display("FAIL unl_bypass got %b want 110", got);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_cmp++;
    if (user_out !== 8'hA5 || user_update !== 1'b0) begin
      n_bad++;
      $display("FAIL unl_user_side got %h/%b want a5/0",
               user_out, user_update);
    end
  endtask

  task automatic test_reset_midshift();
    logic [IRW-1:0] cap;
    bit upd_seen;
    upd_seen = 1'b0;
    shift_ir(4'b0010, cap);
    dr_enter();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (tap_state !== 4'h0 || ir_out !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_rst_state got %h/%b want 0/0001",
               tap_state, ir_out);
    end
    n_cmp++;
    if (user_out !== 8'h00 || tdo_en !== 1'b0 || tdo !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_out got %h/%b/%b want 00/0/0",
               user_out, tdo_en, tdo);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      if (user_update !== 1'b0) upd_seen = 1'b1;
    end
    n_cmp++;
    if (upd_seen || user_out !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_rst_upd got %b/%h want 0/00",
               upd_seen, user_out);
    end
    n_cmp++;
    if (tap_state !== 4'h0) begin
      n_bad++;
      $display("FAIL mid_rst_hold got %h want 0", tap_state);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_tlr_all();
    int plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    int pbit [16] = '{0, 0, 2, 2, 2, 10, 10, 42, 26, 6, 6, 6,
                      22, 22, 86, 54};
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < plen[s]; i++) begin
        tick(1'((pbit[s] >> i) & 1), 1'($urandom_range(0, 1)));
      end
      n_cmp++;
      if (tap_state !== 4'(s)) begin
        n_bad++;
        $display("FAIL tlr_reach got %h want %h", tap_state, 4'(s));
      end
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      n_cmp++;
      if (tap_state !== 4'h0 || ir_out !== 4'b0001) begin
        n_bad++;
        $display("FAIL tlr_from_%0d got %h/%b want 0/0001",
                 s, tap_state, ir_out);
      end
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int hits;
    for (int i = 0; i < 32; i++) arc_hit[i] = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) user_in = 8'($urandom);
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if (o_tdo !== e_tdo || o_en !== e_en) begin
        n_bad++;
        $display("FAIL rnd_tdo got %b/%b want %b/%b",
                 o_tdo, o_en, e_tdo, e_en);
      end
      n_cmp++;
      if (tap_state !== 4'(m_st)) begin
        n_bad++;
        $display("FAIL rnd_state got %h want %h",
                 tap_state, 4'(m_st));
      end
      n_cmp++;
      if (ir_out !== m_ir) begin
        n_bad++;
        $display("FAIL rnd_ir got %b want %b", ir_out, m_ir);
      end
      n_cmp++;
      if (user_out !== m_uout || user_update !== m_uupd) begin
        n_bad++;
        $display("FAIL rnd_user got %h/%b want %h/%b",
                 user_out, user_update, m_uout, m_uupd);
      end
    end
    hits = 0;
    for (int i = 0; i < 32; i++) hits += int'(arc_hit[i]);
    n_cmp++;
    if (hits != 32) begin
      n_bad++;
      $display("FAIL rnd_arc_cov got %0d want 32", hits);
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_unlisted();
    test_reset_midshift();
    test_tlr_all();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
